// File: rtl/user_stream_tx_pkg.sv
// rtl/user_stream_tx_pkg.sv - shared constants, OREG state enum and word/occupancy types
//
// Package leaf_stream_pkg.
// It is imported by the transmit adapter and by its interface.
// It holds:
//   - the default stream geometry (word width, array address bits, credit batch size)
//   - the output-register state encoding
//   - the payload word type and the occupancy type
package leaf_stream_pkg;

    localparam int PAYLOAD_BITS          = 32;
    localparam int NUM_BRAM_ADDR_BITS    = 7;
    localparam int FREESPACE_UPDATE_SIZE = 64;

    typedef enum logic {
        OEMPTY = 1'b0,
        OFULL  = 1'b1
    } oreg_state_e;

    typedef logic [PAYLOAD_BITS-1:0]     payload_t;
    typedef logic [NUM_BRAM_ADDR_BITS:0] occ_t;

    // Width of a counter that must reach 'n' inclusive.
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/user_stream_tx_if.sv
// rtl/user_stream_tx_if.sv - ap_vld/ap_ack word stream toward the HLS operator
//
// Signals:
//   dout_user : word presented to the operator
//   vld_user  : dout_user valid (ap_vld)
//   ack_user  : operator accepts the word (ap_ack)
// Modports:
//   master : the transmit adapter, which drives the data and valid
//   slave  : the operator, which drives the acknowledge
interface user_stream_tx_if #(
    parameter int PAYLOAD_BITS = leaf_stream_pkg::PAYLOAD_BITS
);
    logic [PAYLOAD_BITS-1:0] dout_user;
    logic                    vld_user;
    logic                    ack_user;

    modport master (output dout_user, output vld_user, input ack_user);
    modport slave  (input dout_user, input vld_user, output ack_user);
endinterface

// File: rtl/user_stream_tx_ram.sv
// rtl/user_stream_tx_ram.sv - simple dual-port word array, synchronous write, combinational read
//
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, available in the same cycle as raddr_i
// The array is left unreset so that it infers as LUTRAM/BRAM.
module user_stream_tx_ram #(
    parameter int WIDTH = 32,
    parameter int ABITS = 7
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [2**ABITS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/user_stream_tx.sv
// rtl/user_stream_tx.sv - push-side FIFO feeding an HLS ap_vld/ap_ack input stream, with credit return
//
// Optional feature macro: USER_STREAM_TX_STALL_CNT_EN.
// When it is defined, the stall_cnt output counts cycles with vld_user=1 and ack_user=0.
//
// Ports:
//   clk_user      : the only clock
//   reset         : synchronous active-high reset
//   din_wr        : word pushed from the interface side
//   wr_en         : push strobe; ignored while full
//   full          : array holds D words
//   empty         : array and output register both empty
//   op            : operator stream (dout_user/vld_user/ack_user), master side
//   freespace_upd : one-cycle pulse per FREESPACE_UPDATE_SIZE consumed words
//   freespace_cnt : registered count of free array entries
//   stall_cnt     : (optional) saturating count of stalled cycles
//
// Storage is a D-entry array plus one output register (OREG), so the
// capacity is D+1 words.
// When the array is empty and the OREG is free or being consumed, a push
// goes straight into the OREG, giving a one-cycle first-word latency.
module user_stream_tx
    import leaf_stream_pkg::*;
#(
    parameter int PAYLOAD_BITS          = leaf_stream_pkg::PAYLOAD_BITS,
    parameter int NUM_BRAM_ADDR_BITS    = leaf_stream_pkg::NUM_BRAM_ADDR_BITS,
    parameter int FREESPACE_UPDATE_SIZE = leaf_stream_pkg::FREESPACE_UPDATE_SIZE
) (
    input  logic                        clk_user,
    input  logic                        reset,
    input  logic [PAYLOAD_BITS-1:0]     din_wr,
    input  logic                        wr_en,
    output logic                        full,
    output logic                        empty,
    user_stream_tx_if.master            op,
    output logic                        freespace_upd,
`ifdef USER_STREAM_TX_STALL_CNT_EN
    output logic [15:0]                 stall_cnt,
`endif
    output logic [NUM_BRAM_ADDR_BITS:0] freespace_cnt
);
    localparam int AB    = NUM_BRAM_ADDR_BITS;
    localparam int DEPTH = 1 << AB;
    localparam int CW    = cnt_bits(FREESPACE_UPDATE_SIZE);

    localparam logic [AB:0]   DEPTH_OCC = (AB+1)'(DEPTH);
    localparam logic [CW-1:0] CRED_LAST = CW'(FREESPACE_UPDATE_SIZE - 1);

    oreg_state_e             state_q;
    logic [PAYLOAD_BITS-1:0] oreg_q;
    logic [AB-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AB:0]             occ_q, occ_d;
    logic [AB:0]             freespace_q;
    logic [CW-1:0]           cred_q;
    logic                    upd_q;
    logic [PAYLOAD_BITS-1:0] rd_data;

    logic consume, oreg_free, arr_nempty, push_ok, ld_arr, bypass, wr_arr;

    assign consume    = (state_q == OFULL) && op.ack_user;
    // The OREG can take a new word this cycle if it is empty or being emptied.
    assign oreg_free  = (state_q == OEMPTY) || consume;
    assign arr_nempty = (occ_q != '0);
    assign full       = (occ_q == DEPTH_OCC);
    assign push_ok    = wr_en && !full;
    assign ld_arr     = oreg_free && arr_nempty;
    // Bypass only when the array is empty, which keeps the words in order.
    assign bypass     = oreg_free && !arr_nempty && push_ok;
    assign wr_arr     = push_ok && !bypass && !reset;

    assign occ_d = occ_q + (AB+1)'(wr_arr) - (AB+1)'(ld_arr);

    // The array write never hits the read address while a word is loaded
    // from it: equal pointers with a non-empty array mean it is full, and
    // pushes are refused while full.
    user_stream_tx_ram #(
        .WIDTH (PAYLOAD_BITS),
        .ABITS (AB)
    ) u_ram (
        .clk_i   (clk_user),
        .we_i    (wr_arr),
        .waddr_i (wr_ptr_q),
        .wdata_i (din_wr),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk_user) begin
        if (reset) begin
            state_q     <= OEMPTY;
            oreg_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            freespace_q <= DEPTH_OCC;
            cred_q      <= '0;
            upd_q       <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            freespace_q <= DEPTH_OCC - occ_d;
            if (wr_arr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (ld_arr) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            case (state_q)
                OEMPTY: begin
                    if (ld_arr) begin
                        oreg_q  <= rd_data;
                        state_q <= OFULL;
                    end else if (bypass) begin
                        oreg_q  <= din_wr;
                        state_q <= OFULL;
                    end
                end
                OFULL: begin
                    if (consume) begin
                        if (ld_arr) begin
                            oreg_q <= rd_data;
                        end else if (bypass) begin
                            oreg_q <= din_wr;
                        end else begin
                            state_q <= OEMPTY;
                        end
                    end
                end
                default: state_q <= OEMPTY;
            endcase

            upd_q <= 1'b0;
            if (consume) begin
                if (cred_q == CRED_LAST) begin
                    cred_q <= '0;
                    upd_q  <= 1'b1;
                end else begin
                    cred_q <= cred_q + 1'b1;
                end
            end
        end
    end

    assign op.dout_user  = oreg_q;
    assign op.vld_user   = (state_q == OFULL);
    assign empty         = (occ_q == '0) && (state_q == OEMPTY);
    assign freespace_upd = upd_q;
    assign freespace_cnt = freespace_q;

`ifdef USER_STREAM_TX_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_user) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == OFULL) && !op.ack_user && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_user_stream_tx.sv
// tb/tb_user_stream_tx.sv - directed self-checking bench for user_stream_tx
module tb_user_stream_tx;
    logic        clk_user = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] din_wr   = '0;
    logic        wr_en    = 1'b0;
    logic        full, empty, freespace_upd;
    logic [7:0]  freespace_cnt;
`ifdef USER_STREAM_TX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    user_stream_tx_if #(.PAYLOAD_BITS(32)) uif ();

    user_stream_tx dut (
        .clk_user      (clk_user),
        .reset         (reset),
        .din_wr        (din_wr),
        .wr_en         (wr_en),
        .full          (full),
        .empty         (empty),
        .op            (uif),
        .freespace_upd (freespace_upd),
`ifdef USER_STREAM_TX_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .freespace_cnt (freespace_cnt)
    );

    always #5 clk_user = ~clk_user;

    task automatic tick();
        @(posedge clk_user);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        uif.ack_user = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (uif.vld_user !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || freespace_cnt !== 8'd128
            || freespace_upd !== 1'b0 || uif.dout_user !== 32'd0) begin
            bad++;
            $display("FAIL reset_state vld=%b empty=%b full=%b fs=%0d upd=%b dout=%h want 0 1 0 128 0 0",
                     uif.vld_user, empty, full, freespace_cnt, freespace_upd, uif.dout_user);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (uif.vld_user !== 1'b0 || empty !== 1'b1 || freespace_upd !== 1'b0 || freespace_cnt !== 8'd128) begin
                bad++;
                $display("FAIL idle cyc=%0d vld=%b empty=%b upd=%b fs=%0d want 0 1 0 128",
                         i, uif.vld_user, empty, freespace_upd, freespace_cnt);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        din_wr = 32'hDEADBEEF;
        wr_en  = 1'b1;
        tick();
        wr_en  = 1'b0;
        din_wr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (uif.vld_user !== 1'b1 || uif.dout_user !== 32'hDEADBEEF || empty !== 1'b0) begin
                bad++;
                $display("FAIL single_hold cyc=%0d vld=%b dout=%h empty=%b want 1 deadbeef 0",
                         i, uif.vld_user, uif.dout_user, empty);
            end
            tick();
        end
        uif.ack_user = 1'b1;
        tick();
        uif.ack_user = 1'b0;
        total++;
        if (uif.vld_user !== 1'b0 || empty !== 1'b1 || freespace_cnt !== 8'd128) begin
            bad++;
            $display("FAIL single_consumed vld=%b empty=%b fs=%0d want 0 1 128", uif.vld_user, empty, freespace_cnt);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 129; i++) begin
            din_wr = 32'(i);
            tick();
        end
        total++;
        if (full !== 1'b1 || freespace_cnt !== 8'd0 || uif.vld_user !== 1'b1 || uif.dout_user !== 32'd0 || empty !== 1'b0) begin
            bad++;
            $display("FAIL fill full=%b fs=%0d vld=%b dout=%0d empty=%b want 1 0 1 0 0",
                     full, freespace_cnt, uif.vld_user, uif.dout_user, empty);
        end
        din_wr = 32'd999;
        tick();
        wr_en = 1'b0;
        total++;
        if (full !== 1'b1 || freespace_cnt !== 8'd0 || uif.dout_user !== 32'd0) begin
            bad++;
            $display("FAIL dropped_push full=%b fs=%0d dout=%0d want 1 0 0", full, freespace_cnt, uif.dout_user);
        end
        uif.ack_user = 1'b1;
        for (int i = 0; i < 129; i++) begin
            total++;
            if (uif.vld_user !== 1'b1 || uif.dout_user !== 32'(i)) begin
                bad++;
                $display("FAIL drain idx=%0d vld=%b dout=%0d want 1 %0d", i, uif.vld_user, uif.dout_user, i);
            end
            tick();
        end
        total++;
        if (uif.vld_user !== 1'b0 || empty !== 1'b1 || freespace_cnt !== 8'd128 || full !== 1'b0) begin
            bad++;
            $display("FAIL drain_end vld=%b empty=%b fs=%0d full=%b want 0 1 128 0",
                     uif.vld_user, empty, freespace_cnt, full);
        end
        uif.ack_user = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pi, ci, pulses;
        logic prev_cons, cons, seen;
        do_reset();
        pi = 0; ci = 0; pulses = 0; prev_cons = 1'b0; seen = 1'b0;
        uif.ack_user = 1'b1;
        for (int cyc = 0; cyc < 210; cyc++) begin
            total++;
            if (freespace_upd !== (prev_cons && ci != 0 && (ci % 64) == 0)) begin
                bad++;
                $display("FAIL stream_upd cyc=%0d consumed=%0d upd=%b want %b",
                         cyc, ci, freespace_upd, (prev_cons && ci != 0 && (ci % 64) == 0));
            end
            if (freespace_upd === 1'b1) pulses++;
            if (seen && ci < 200) begin
                total++;
                if (uif.vld_user !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_gap cyc=%0d consumed=%0d vld=%b want 1", cyc, ci, uif.vld_user);
                end
            end
            if (uif.vld_user === 1'b1) seen = 1'b1;
            wr_en  = (pi < 200);
            din_wr = 32'(pi) ^ 32'hA5A5_0000;
            cons   = (uif.vld_user === 1'b1);
            if (cons) begin
                total++;
                if (uif.dout_user !== (32'(ci) ^ 32'hA5A5_0000)) begin
                    bad++;
                    $display("FAIL stream_data idx=%0d dout=%h want %h", ci, uif.dout_user, 32'(ci) ^ 32'hA5A5_0000);
                end
            end
            tick();
            if (wr_en) pi++;
            if (cons) ci++;
            prev_cons = cons;
        end
        wr_en = 1'b0;
        uif.ack_user = 1'b0;
        total++;
        if (ci != 200 || pulses != 3) begin
            bad++;
            $display("FAIL stream_totals consumed=%0d pulses=%0d want 200 3", ci, pulses);
        end
    endtask

    task automatic test_reset_mid();
        int ci, pulse_at;
        logic cons;
        do_reset();
        wr_en = 1'b1;
        uif.ack_user = 1'b1;
        for (int i = 0; i < 11; i++) begin
            din_wr = 32'(i);
            tick();
        end
        uif.ack_user = 1'b0;
        for (int i = 0; i < 49; i++) begin
            din_wr = 32'(100 + i);
            tick();
        end
        wr_en = 1'b0;
        total++;
        if (freespace_cnt !== 8'd79 || uif.vld_user !== 1'b1) begin
            bad++;
            $display("FAIL mid_buffered fs=%0d vld=%b want 79 1", freespace_cnt, uif.vld_user);
        end
        reset = 1'b1;
        wr_en = 1'b1;
        uif.ack_user = 1'b1;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        uif.ack_user = 1'b0;
        total++;
        if (uif.vld_user !== 1'b0 || empty !== 1'b1 || freespace_cnt !== 8'd128 || full !== 1'b0 || freespace_upd !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset vld=%b empty=%b fs=%0d full=%b upd=%b want 0 1 128 0 0",
                     uif.vld_user, empty, freespace_cnt, full, freespace_upd);
        end
        ci = 0;
        pulse_at = -1;
        wr_en = 1'b1;
        uif.ack_user = 1'b1;
        for (int cyc = 0; cyc < 90 && pulse_at < 0; cyc++) begin
            din_wr = 32'(cyc);
            cons = (uif.vld_user === 1'b1);
            tick();
            if (cons) ci++;
            if (freespace_upd === 1'b1) pulse_at = ci;
        end
        wr_en = 1'b0;
        uif.ack_user = 1'b0;
        total++;
        if (pulse_at != 64) begin
            bad++;
            $display("FAIL mid_credit pulse_after=%0d consumes want 64", pulse_at);
        end
    endtask

`ifdef USER_STREAM_TX_STALL_CNT_EN
    task automatic test_stall();
        do_reset();
        din_wr = 32'h1234_5678;
        wr_en  = 1'b1;
        tick();
        wr_en  = 1'b0;
        for (int i = 0; i < 37; i++) tick();
        uif.ack_user = 1'b1;
        tick();
        uif.ack_user = 1'b0;
        total++;
        if (stall_cnt !== 16'd37) begin
            bad++;
            $display("FAIL stall_cnt got=%0d want 37", stall_cnt);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (stall_cnt !== 16'd37) begin
            bad++;
            $display("FAIL stall_hold got=%0d want 37", stall_cnt);
        end
    endtask
`endif

    initial begin
        uif.ack_user = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_reset_mid();
`ifdef USER_STREAM_TX_STALL_CNT_EN
        test_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
